// File: rtl/ro_odometer_ctrl_pkg.sv
// Shared definitions for the RO odometer sequencer: decoder mode encodings,
// FSM states and the saturating aging-delta helper.
package ro_odometer_ctrl_pkg;

  localparam int unsigned DATA_W = 32;

  // Same encodings as the downstream decoder's mode input
  typedef enum logic [1:0] {
    MODE_RST    = 2'b00,
    MODE_STRESS = 2'b01,
    MODE_MEAS   = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    MEASURE = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Stressed RO runs slower, so a faster stressed count is clamped to zero
  function automatic logic [DATA_W-1:0] sat_delta(input logic [DATA_W-1:0] r,
                                                  input logic [DATA_W-1:0] s);
    return (r > s) ? (r - s) : '0;
  endfunction

endpackage

// File: rtl/ro_odometer_ctrl_sync_2ff.sv
// Two-flop synchronizer with async reset and a synchronous flush so stale
// history is discarded before a new measurement starts.
module ro_odometer_ctrl_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else if (clr_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ro_odometer_ctrl.sv
// Scan sequencer for the CDIR odometer decoder: walks every sensor, captures
// per-sensor aging deltas and reports sum, max and the aged verdict.
module ro_odometer_ctrl
  import ro_odometer_ctrl_pkg::*;
#(
  parameter int unsigned NO_CDIR       = 8,
  parameter int unsigned MUX_SEL_SIZE  = $clog2(NO_CDIR),
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1024,
  parameter logic [31:0] AGE_THRESH    = 32'd5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stress_en,
  input  logic [DATA_W-1:0]              r_freq,
  input  logic [DATA_W-1:0]              s_freq,
  input  logic                           valid_in,
  output logic [1:0]                     mode,
  output logic [MUX_SEL_SIZE-1:0]        r_mux_sel,
  output logic [MUX_SEL_SIZE-1:0]        s_mux_sel,
  output logic                           busy,
  output logic                           res_valid,
  output logic [MUX_SEL_SIZE-1:0]        res_idx,
  output logic [DATA_W-1:0]              res_delta,
  output logic [DATA_W+MUX_SEL_SIZE-1:0] delta_sum,
  output logic [DATA_W-1:0]              delta_max,
  output logic                           aged,
  output logic                           err,
  output logic                           done
);

  localparam int unsigned SUM_W = DATA_W + MUX_SEL_SIZE;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MUX_SEL_SIZE-1:0] idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    res_valid_q, res_valid_d;
  logic [MUX_SEL_SIZE-1:0] res_idx_q, res_idx_d;
  logic [DATA_W-1:0]       res_delta_q, res_delta_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [DATA_W-1:0]       max_q, max_d;
  logic                    aged_q, aged_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       delta_c;
  logic                    valid_sync;

  ro_odometer_ctrl_sync_2ff u_valid_sync (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == CLEAR),
    .d_i   (valid_in),
    .q_o   (valid_sync)
  );

  assign delta_c = sat_delta(r_freq, s_freq);

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_delta_d = res_delta_q;
    sum_d       = sum_q;
    max_d       = max_q;
    aged_d      = aged_q;
    err_d       = err_q;
    done_d      = done_q;
    mode_d      = MODE_RST;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          idx_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          aged_d  = 1'b0;
          err_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      CLEAR: begin
        if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (valid_sync) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        res_valid_d = 1'b1;
        res_idx_d   = idx_q;
        res_delta_d = delta_c;
        sum_d       = sum_q + SUM_W'(delta_c);
        if (delta_c > max_q) max_d = delta_c;
        if (idx_q == MUX_SEL_SIZE'(NO_CDIR - 1)) begin
          state_d = DONE;
        end else begin
          state_d = CLEAR;
          idx_d   = idx_q + MUX_SEL_SIZE'(1);
          cnt_d   = '0;
        end
      end
      DONE: begin
        // Average is sum / NO_CDIR; a timed-out scan is never reported aged
        aged_d  = !err_q && ((sum_q >> MUX_SEL_SIZE) > SUM_W'(AGE_THRESH));
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Mode and busy follow the state being entered so they line up with it
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:                     mode_d = stress_en ? MODE_STRESS : MODE_RST;
      MEASURE, SETTLE, CAPTURE: mode_d = MODE_MEAS;
      default:                  mode_d = MODE_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_RST;
      cnt_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_delta_q <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      aged_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_delta_q <= res_delta_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      aged_q      <= aged_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // Selects come from idx, which only moves on entry to CLEAR
  assign mode      = mode_q;
  assign r_mux_sel = idx_q;
  assign s_mux_sel = idx_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_delta = res_delta_q;
  assign delta_sum = sum_q;
  assign delta_max = max_q;
  assign aged      = aged_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule
